// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: byte width and the sequencer state encoding.
package arith_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/cla8_slice.sv
// 8-bit carry-lookahead adder slice with carry-in; purely combinational.
module cla8_slice
    import arith_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of products: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i:0]ci
    always_comb begin
        logic term;
        logic prod;
        c    = '0;
        term = 1'b0;
        prod = 1'b0;
        c[0] = ci;
        for (int unsigned i = 0; i < BYTE_W; i++) begin
            term = ci;
            for (int unsigned j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            for (int unsigned j = 0; j <= i; j++) begin
                prod = g[j];
                for (int unsigned k = j + 1; k <= i; k++) begin
                    prod = prod & p[k];
                end
                term = term | prod;
            end
            c[i+1] = term;
        end
    end

    assign s  = p ^ c[BYTE_W-1:0];
    assign co = c[BYTE_W];

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Wide add/subtract built from one 8-bit CLA slice stepped LSB byte first,
// with the carry chained through a 1-bit register between cycles.
module multibyte_add_sequencer
    import arith_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                   cout,
    output logic                   overflow,
    output logic                   busy
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t            state;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic              carry;
    logic [IW-1:0]     idx;
    logic [BYTE_W-1:0] s_byte;
    logic              co_byte;

    cla8_slice u_slice (
        .a  (a_r[BYTE_W*idx +: BYTE_W]),
        .b  (b_r[BYTE_W*idx +: BYTE_W]),
        .ci (carry),
        .s  (s_byte),
        .co (co_byte)
    );

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[BYTE_W*idx +: BYTE_W] <= s_byte;
                    carry                     <= co_byte;
                    if (idx == LAST) begin
                        cout      <= co_byte;
                        // s_byte[7] is the MSB of the final result on this cycle
                        overflow  <= (a_r[W-1] == b_r[W-1]) && (s_byte[BYTE_W-1] != a_r[W-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
